rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
- Parametrised successor of the integer reservation station; sits between issue and the ALU, holding up to DEPTH decoded ops until their operands arrive.
- Snoops N_CDB result buses. Operands broadcast in the same cycle as their issue are forwarded into the new entry.
- Dispatches the oldest ready entry (age order, not slot index) through a valid/ready handshake with the ALU.
- Publishes occupancy and a next-cycle-full flag to issue.

Parameters:
DEPTH, 16, number of entries (>=2)
TAG_W, 5, ROB tag width; tag 0 = "operand valid, no producer"
DATA_W, 32, operand/result width
OP_W, 6, opcode enum width
N_CDB, 2, number of result broadcast channels (ALU, LSB, ...)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; when low all state holds
clr  in  1  synchronous flush (mispredict), active-high
issue_valid  in  1  new entry this cycle
issue_op  in  OP_W  opcode
issue_tag  in  TAG_W  destination ROB tag
issue_rs1_val, issue_rs2_val  in  DATA_W  operand values (meaningful when tag==0)
issue_rs1_tag, issue_rs2_tag  in  TAG_W  producer tags
issue_imm  in  DATA_W  immediate
issue_pc  in  32  instruction PC
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_tag  in  N_CDB*TAG_W  packed tags, channel k at [k*TAG_W +: TAG_W]
cdb_val  in  N_CDB*DATA_W  packed results
disp_valid  out  1  dispatch register holds an op
disp_ready  in  1  ALU accepts this cycle
disp_op, disp_tag, disp_rs1_val, disp_rs2_val, disp_imm, disp_pc  out  as issue  dispatched fields
count  out  CNT_W  entries busy
next_full  out  1  (count_next == DEPTH), combinational

Behaviour:
- Reset (rst=0, async): all busy=0, age matrix cleared, count=0, disp_valid=0. Dispatch data regs are 0.
- clr=1 (when rdy=1): same effect as reset on the next edge; it overrides issue, CDB and dispatch in that cycle.
- rdy=0: no state changes. next_full is still driven.
- Entry ready: busy, rs1_tag==0 and rs2_tag==0, evaluated on registered state.
- Wakeup: for each busy entry, operand, and channel k with cdb_valid[k] and cdb_tag_k==operand tag!=0:
  - latch cdb_val_k and set the tag to 0.
  - Lowest k wins if several channels match (tags are unique, so this is illegal anyway).
- Issue forwarding: if an issue operand tag matches a valid broadcast in the same cycle, the entry stores the CDB value with tag 0.
- Allocation: lowest-index free slot, chosen from pre-edge busy. A slot freed by dispatch this cycle is not reusable until the next cycle.
- Issue while count==DEPTH is ignored: no write, count unchanged. It is a protocol error; issue must obey next_full.
- Age: DEPTH x DEPTH matrix, older[i][j]=1 when i was allocated before j.
  - On allocation of slot s: row s is cleared and column s is set for all busy entries.
  - Selection picks the ready entry with no ready older entry.
- Dispatch handshake: the dispatch register loads when rdy and (!disp_valid or disp_ready).
  - If a ready entry exists: load it, set disp_valid=1, free the slot.
  - Else: disp_valid=0.
  - While disp_valid and !disp_ready: the register holds stable and no selection occurs.
- Latency: issue with both tags 0 at edge N -> disp_valid at edge N+1 (empty RS, idle ALU). A CDB wakeup at edge N -> dispatch at edge N+1.
- count_next = count + accepted_issue - dispatched. It never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package (definition include): TAG_W, DATA_W, OP_W, ADDR width, TAG_NONE=0, opcode enum.
- Sub-module rs_age_select: takes the ready vector and age matrix, returns a one-hot grant plus a found flag. It is purely combinational and is reused by the future LSB scheduler.

Test Plan:
- Reset mid-operation: fill 5 entries, pulse rst low asynchronously -> count=0, disp_valid=0 immediately, next_full=0.
- Age order: issue A(tag3) to slot 2, B(tag4) to slot 0 (after a free), both ready -> A dispatches first, then B.
- Multi-CDB wakeup: entry waiting rs1=7, rs2=9; cdb ch0 tag7 val 0x11, ch1 tag9 val 0x22 same cycle -> next edge disp_rs1_val=0x11, disp_rs2_val=0x22.
- Issue forwarding: issue rs1_tag=6 while cdb_valid tag6 val 0xDEAD -> entry ready immediately, dispatched next edge with rs1=0xDEAD.
- Backpressure: disp_ready=0 for 3 cycles with 2 ready entries -> disp fields stable, count unchanged; disp_ready=1 -> second op loads next edge.
- Full/clr: issue DEPTH ops with tags nonzero -> next_full=1 on the cycle of the final issue; extra issue ignored; clr=1 -> count=0, disp_valid=0.

Source files
------------

// File: rtl/rs_multi_cdb_pkg.sv
// Shared widths, the "no producer" tag value and the ALU opcode set for the
// integer reservation station and the schedulers derived from it.
package rs_multi_cdb_pkg;

    localparam int RS_TAG_W  = 5;
    localparam int RS_DATA_W = 32;
    localparam int RS_OP_W   = 6;
    localparam int RS_ADDR_W = 32;

    localparam logic [RS_TAG_W-1:0] TAG_NONE = 5'd0;

    typedef enum logic [RS_OP_W-1:0] {
        OP_ADD   = 6'd0,
        OP_SUB   = 6'd1,
        OP_AND   = 6'd2,
        OP_OR    = 6'd3,
        OP_XOR   = 6'd4,
        OP_SLL   = 6'd5,
        OP_SRL   = 6'd6,
        OP_SRA   = 6'd7,
        OP_SLT   = 6'd8,
        OP_SLTU  = 6'd9,
        OP_LUI   = 6'd10,
        OP_AUIPC = 6'd11
    } alu_op_e;

endpackage

// File: rtl/rs_multi_cdb_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is
// older than. older[i*DEPTH+j] set means entry i was allocated before entry j.
module rs_age_select
    import rs_multi_cdb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]       ready,
    input  logic [DEPTH*DEPTH-1:0] older,
    output logic [DEPTH-1:0]       grant,
    output logic                   found
);

    logic [DEPTH-1:0] blocked_s;

    // An entry is blocked when any ready entry is older than it
    always_comb begin
        blocked_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s[i] = blocked_s[i] | (ready[j] & older[j*DEPTH+i]);
            end
        end
    end

    assign grant = ready & ~blocked_s;
    assign found = |grant;

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with multi-channel CDB snooping, issue-time forwarding
// and age-ordered dispatch through a valid/ready output register.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W,
    parameter int OP_W   = RS_OP_W,
    parameter int N_CDB  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clr,
    input  logic                    issue_valid,
    input  logic [OP_W-1:0]         issue_op,
    input  logic [TAG_W-1:0]        issue_tag,
    input  logic [DATA_W-1:0]       issue_rs1_val,
    input  logic [DATA_W-1:0]       issue_rs2_val,
    input  logic [TAG_W-1:0]        issue_rs1_tag,
    input  logic [TAG_W-1:0]        issue_rs2_tag,
    input  logic [DATA_W-1:0]       issue_imm,
    input  logic [RS_ADDR_W-1:0]    issue_pc,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_val,
    output logic                    disp_valid,
    input  logic                    disp_ready,
    output logic [OP_W-1:0]         disp_op,
    output logic [TAG_W-1:0]        disp_tag,
    output logic [DATA_W-1:0]       disp_rs1_val,
    output logic [DATA_W-1:0]       disp_rs2_val,
    output logic [DATA_W-1:0]       disp_imm,
    output logic [RS_ADDR_W-1:0]    disp_pc,
    output logic [CNT_W-1:0]        count,
    output logic                    next_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    logic [DEPTH-1:0]            busy_r;
    logic [OP_W-1:0]             op_r      [DEPTH];
    logic [TAG_W-1:0]            tag_r     [DEPTH];
    logic [TAG_W-1:0]            rs1_tag_r [DEPTH];
    logic [TAG_W-1:0]            rs2_tag_r [DEPTH];
    logic [DATA_W-1:0]           rs1_val_r [DEPTH];
    logic [DATA_W-1:0]           rs2_val_r [DEPTH];
    logic [DATA_W-1:0]           imm_r     [DEPTH];
    logic [RS_ADDR_W-1:0]        pc_r      [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older_r;
    logic [CNT_W-1:0]            count_r;

    logic [DEPTH-1:0]  ready_s;
    logic [DEPTH-1:0]  grant_s;
    logic              found_s;
    logic              disp_load_s;
    logic              disp_fire_s;
    logic              alloc_s;
    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [DATA_W:0]   rs1_wake_s [DEPTH];
    logic [DATA_W:0]   rs2_wake_s [DEPTH];
    logic [DATA_W:0]   iss1_fwd_s;
    logic [DATA_W:0]   iss2_fwd_s;
    logic [CNT_W-1:0]  count_next_s;

    // Returns {hit, value}; scanning downward lets the lowest channel win
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        vld,
        input logic [N_CDB*TAG_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            res = (vld[k] && (tag != NO_TAG) && (tags[k*TAG_W +: TAG_W] == tag))
                ? {1'b1, vals[k*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    // Per-entry readiness and CDB wakeup candidates from registered tags
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i]    = busy_r[i] && (rs1_tag_r[i] == NO_TAG) && (rs2_tag_r[i] == NO_TAG);
            rs1_wake_s[i] = cdb_lookup(rs1_tag_r[i], cdb_valid, cdb_tag, cdb_val);
            rs2_wake_s[i] = cdb_lookup(rs2_tag_r[i], cdb_valid, cdb_tag, cdb_val);
        end
    end

    assign iss1_fwd_s = cdb_lookup(issue_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    assign iss2_fwd_s = cdb_lookup(issue_rs2_tag, cdb_valid, cdb_tag, cdb_val);

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .ready (ready_s),
        .older (older_r),
        .grant (grant_s),
        .found (found_s)
    );

    // Lowest free slot from pre-edge busy, and index of the granted entry
    always_comb begin
        free_idx_s = '0;
        sel_idx_s  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = !busy_r[i] ? IDX_W'(i) : free_idx_s;
            sel_idx_s  = grant_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end

    assign free_found_s = ~&busy_r;
    assign alloc_s      = issue_valid && free_found_s;
    assign disp_load_s  = !disp_valid || disp_ready;
    assign disp_fire_s  = disp_load_s && found_s;

    // Occupancy after this edge, exposed to issue as next_full
    always_comb begin
        if (!rdy) begin
            count_next_s = count_r;
        end else if (clr) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CNT_W'(alloc_s) - CNT_W'(disp_fire_s);
        end
    end

    assign next_full = (count_next_s == CNT_W'(DEPTH));
    assign count     = count_r;

    // Entry array, age matrix, dispatch register and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= '0;
            older_r      <= '0;
            count_r      <= '0;
            disp_valid   <= 1'b0;
            disp_op      <= '0;
            disp_tag     <= '0;
            disp_rs1_val <= '0;
            disp_rs2_val <= '0;
            disp_imm     <= '0;
            disp_pc      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]      <= '0;
                tag_r[i]     <= '0;
                rs1_tag_r[i] <= '0;
                rs2_tag_r[i] <= '0;
                rs1_val_r[i] <= '0;
                rs2_val_r[i] <= '0;
                imm_r[i]     <= '0;
                pc_r[i]      <= '0;
            end
        end else if (rdy) begin
            if (clr) begin
                busy_r       <= '0;
                older_r      <= '0;
                count_r      <= '0;
                disp_valid   <= 1'b0;
                disp_op      <= '0;
                disp_tag     <= '0;
                disp_rs1_val <= '0;
                disp_rs2_val <= '0;
                disp_imm     <= '0;
                disp_pc      <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_r[i] && rs1_wake_s[i][DATA_W]) begin
                        rs1_tag_r[i] <= NO_TAG;
                        rs1_val_r[i] <= rs1_wake_s[i][DATA_W-1:0];
                    end
                    if (busy_r[i] && rs2_wake_s[i][DATA_W]) begin
                        rs2_tag_r[i] <= NO_TAG;
                        rs2_val_r[i] <= rs2_wake_s[i][DATA_W-1:0];
                    end
                end

                if (alloc_s) begin
                    busy_r[free_idx_s]    <= 1'b1;
                    op_r[free_idx_s]      <= issue_op;
                    tag_r[free_idx_s]     <= issue_tag;
                    rs1_tag_r[free_idx_s] <= iss1_fwd_s[DATA_W] ? NO_TAG : issue_rs1_tag;
                    rs1_val_r[free_idx_s] <= iss1_fwd_s[DATA_W] ? iss1_fwd_s[DATA_W-1:0] : issue_rs1_val;
                    rs2_tag_r[free_idx_s] <= iss2_fwd_s[DATA_W] ? NO_TAG : issue_rs2_tag;
                    rs2_val_r[free_idx_s] <= iss2_fwd_s[DATA_W] ? iss2_fwd_s[DATA_W-1:0] : issue_rs2_val;
                    imm_r[free_idx_s]     <= issue_imm;
                    pc_r[free_idx_s]      <= issue_pc;
                    // New entry is younger than everything currently held
                    for (int j = 0; j < DEPTH; j++) begin
                        older_r[free_idx_s][j] <= 1'b0;
                        if (busy_r[j]) begin
                            older_r[j][free_idx_s] <= 1'b1;
                        end
                    end
                end

                if (disp_load_s) begin
                    if (found_s) begin
                        disp_valid        <= 1'b1;
                        disp_op           <= op_r[sel_idx_s];
                        disp_tag          <= tag_r[sel_idx_s];
                        disp_rs1_val      <= rs1_val_r[sel_idx_s];
                        disp_rs2_val      <= rs2_val_r[sel_idx_s];
                        disp_imm          <= imm_r[sel_idx_s];
                        disp_pc           <= pc_r[sel_idx_s];
                        busy_r[sel_idx_s] <= 1'b0;
                    end else begin
                        disp_valid <= 1'b0;
                    end
                end

                count_r <= count_next_s;
            end
        end
    end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed and randomized checks of rs_multi_cdb against an age-ordered
// queue model of the reservation station.
module tb_rs_multi_cdb;
    import rs_multi_cdb_pkg::*;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int N_CDB  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rdy;
    logic                    clr;
    logic                    issue_valid;
    logic [OP_W-1:0]         issue_op;
    logic [TAG_W-1:0]        issue_tag;
    logic [DATA_W-1:0]       issue_rs1_val;
    logic [DATA_W-1:0]       issue_rs2_val;
    logic [TAG_W-1:0]        issue_rs1_tag;
    logic [TAG_W-1:0]        issue_rs2_tag;
    logic [DATA_W-1:0]       issue_imm;
    logic [31:0]             issue_pc;
    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_val;
    logic                    disp_valid;
    logic                    disp_ready;
    logic [OP_W-1:0]         disp_op;
    logic [TAG_W-1:0]        disp_tag;
    logic [DATA_W-1:0]       disp_rs1_val;
    logic [DATA_W-1:0]       disp_rs2_val;
    logic [DATA_W-1:0]       disp_imm;
    logic [31:0]             disp_pc;
    logic [CNT_W-1:0]        count;
    logic                    next_full;

    rs_multi_cdb #(
        .DEPTH (DEPTH), .TAG_W (TAG_W), .DATA_W (DATA_W),
        .OP_W (OP_W), .N_CDB (N_CDB), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst), .rdy (rdy), .clr (clr),
        .issue_valid (issue_valid), .issue_op (issue_op), .issue_tag (issue_tag),
        .issue_rs1_val (issue_rs1_val), .issue_rs2_val (issue_rs2_val),
        .issue_rs1_tag (issue_rs1_tag), .issue_rs2_tag (issue_rs2_tag),
        .issue_imm (issue_imm), .issue_pc (issue_pc),
        .cdb_valid (cdb_valid), .cdb_tag (cdb_tag), .cdb_val (cdb_val),
        .disp_valid (disp_valid), .disp_ready (disp_ready),
        .disp_op (disp_op), .disp_tag (disp_tag),
        .disp_rs1_val (disp_rs1_val), .disp_rs2_val (disp_rs2_val),
        .disp_imm (disp_imm), .disp_pc (disp_pc),
        .count (count), .next_full (next_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [31:0]       pc;
    } ent_t;

    ent_t mq[$];   // held entries, oldest first
    ent_t md;      // model dispatch register
    bit   mdv;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic void m_lookup(input logic [TAG_W-1:0] tag, output bit hit,
                                     output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        if (tag != 5'd0) begin
            for (int k = 0; k < N_CDB; k++) begin
                if (!hit && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                    hit = 1'b1;
                    val = cdb_val[k*DATA_W +: DATA_W];
                end
            end
        end
    endfunction

    function automatic bit m_any_ready();
        foreach (mq[i]) if (mq[i].t1 == 5'd0 && mq[i].t2 == 5'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_count_next();
        int n;
        if (!rdy) return mq.size();
        if (clr) return 0;
        n = mq.size();
        if ((!mdv || disp_ready) && m_any_ready()) n--;
        if (issue_valid && mq.size() < DEPTH) n++;
        return n;
    endfunction

    function automatic void m_clear();
        mq.delete();
        mdv = 1'b0;
        md  = '{default: '0};
    endfunction

    function automatic void model_edge();
        int pre;
        int f;
        bit h;
        logic [DATA_W-1:0] v;
        ent_t e;
        if (!rdy) return;
        if (clr) begin
            m_clear();
            return;
        end
        pre = mq.size();
        if (!mdv || disp_ready) begin
            f = -1;
            foreach (mq[i]) if (f < 0 && mq[i].t1 == 5'd0 && mq[i].t2 == 5'd0) f = i;
            if (f >= 0) begin
                md  = mq[f];
                mdv = 1'b1;
                mq.delete(f);
            end else begin
                mdv = 1'b0;
            end
        end
        foreach (mq[i]) begin
            m_lookup(mq[i].t1, h, v);
            if (h) begin mq[i].t1 = 5'd0; mq[i].v1 = v; end
            m_lookup(mq[i].t2, h, v);
            if (h) begin mq[i].t2 = 5'd0; mq[i].v2 = v; end
        end
        if (issue_valid && pre < DEPTH) begin
            e.op = issue_op; e.tag = issue_tag; e.imm = issue_imm; e.pc = issue_pc;
            e.t1 = issue_rs1_tag; e.v1 = issue_rs1_val;
            e.t2 = issue_rs2_tag; e.v2 = issue_rs2_val;
            m_lookup(issue_rs1_tag, h, v);
            if (h) begin e.t1 = 5'd0; e.v1 = v; end
            m_lookup(issue_rs2_tag, h, v);
            if (h) begin e.t2 = 5'd0; e.v2 = v; end
            mq.push_back(e);
        end
    endfunction

    task automatic check_outputs();
        check("count", 32'(count), 32'(mq.size()));
        check("disp_valid", 32'(disp_valid), 32'(mdv));
        if (mdv) begin
            check("disp_op", 32'(disp_op), 32'(md.op));
            check("disp_tag", 32'(disp_tag), 32'(md.tag));
            check("disp_rs1_val", disp_rs1_val, md.v1);
            check("disp_rs2_val", disp_rs2_val, md.v2);
            check("disp_imm", disp_imm, md.imm);
            check("disp_pc", disp_pc, md.pc);
        end
    endtask

    // Inputs are already driven; check next_full, clock, advance model, check
    task automatic step();
        #1;
        check("next_full", 32'(next_full), 32'(m_count_next() == DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        issue_valid = 1'b0;
        cdb_valid   = '0;
        clr         = 1'b0;
        rdy         = 1'b1;
    endtask

    task automatic idle();
        rdy = 1'b1; clr = 1'b0; issue_valid = 1'b0;
        issue_op = '0; issue_tag = '0; issue_rs1_val = '0; issue_rs2_val = '0;
        issue_rs1_tag = '0; issue_rs2_tag = '0; issue_imm = '0; issue_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic iss(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                       input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                       input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        issue_valid = 1'b1; issue_op = op; issue_tag = tag;
        issue_rs1_tag = t1; issue_rs1_val = v1;
        issue_rs2_tag = t2; issue_rs2_val = v2;
        issue_imm = $urandom; issue_pc = $urandom;
    endtask

    task automatic cdb(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
        cdb_valid[k] = 1'b1;
        cdb_tag[k*TAG_W +: TAG_W] = tag;
        cdb_val[k*DATA_W +: DATA_W] = val;
    endtask

    task automatic drain();
        disp_ready = 1'b1;
        for (int n = 0; n < 40 && (disp_valid || count != '0); n++) step();
        check("drain_empty", 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] snap_rs1;
        rst = 1'b1; disp_ready = 1'b0;
        idle();
        m_clear();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_disp_op", 32'(disp_op), 32'd0);
        check("rst_disp_rs1", disp_rs1_val, 32'd0);
        check("rst_next_full", 32'(next_full), 32'd0);
        rst = 1'b1;

        // Latency: ready issue at edge N appears at edge N+1
        disp_ready = 1'b1;
        iss(6'd1, 5'd2, 5'd0, 32'h100, 5'd0, 32'h200); step();
        step();
        check("lat_disp_valid", 32'(disp_valid), 32'd1);
        check("lat_disp_rs2", disp_rs2_val, 32'h200);
        step();

        // Age order: A lands in slot 2, B later in slot 0, A must go first
        disp_ready = 1'b0;
        iss(6'd2, 5'd1, 5'd0, 32'h1, 5'd0, 32'h2); step();
        iss(6'd3, 5'd10, 5'd20, 32'h0, 5'd0, 32'h3); step();
        iss(6'd4, 5'd11, 5'd21, 32'h0, 5'd0, 32'h4); step();
        iss(6'd5, 5'd3, 5'd0, 32'hA1, 5'd0, 32'hA2); step();
        cdb(0, 5'd21, 32'h55); step();
        disp_ready = 1'b1; step();
        check("age_woken_first", 32'(disp_tag), 32'd11);
        disp_ready = 1'b0;
        iss(6'd6, 5'd4, 5'd0, 32'hB1, 5'd0, 32'hB2); step();
        disp_ready = 1'b1; step();
        check("age_a_first", 32'(disp_tag), 32'd3);
        step();
        check("age_b_second", 32'(disp_tag), 32'd4);
        cdb(1, 5'd20, 32'h66); step();
        drain();

        // Two channels wake both operands in the same cycle
        iss(6'd7, 5'd12, 5'd7, 32'h0, 5'd9, 32'h0); step();
        cdb(0, 5'd7, 32'h11); cdb(1, 5'd9, 32'h22); step();
        step();
        check("mcdb_valid", 32'(disp_valid), 32'd1);
        check("mcdb_rs1", disp_rs1_val, 32'h11);
        check("mcdb_rs2", disp_rs2_val, 32'h22);
        step();

        // Issue-time forwarding
        iss(6'd8, 5'd13, 5'd6, 32'h123, 5'd0, 32'h5);
        cdb(1, 5'd6, 32'hDEAD); step();
        step();
        check("fwd_rs1", disp_rs1_val, 32'hDEAD);
        step();

        // Backpressure holds the dispatch register
        disp_ready = 1'b0;
        iss(6'd9, 5'd14, 5'd0, 32'hC1, 5'd0, 32'hC2); step();
        iss(6'd10, 5'd15, 5'd0, 32'hD1, 5'd0, 32'hD2); step();
        snap_rs1 = md.v1;
        for (int n = 0; n < 3; n++) begin
            step();
            check("bp_tag", 32'(disp_tag), 32'd14);
            check("bp_rs1", disp_rs1_val, snap_rs1);
            check("bp_count", 32'(count), 32'd1);
        end
        disp_ready = 1'b1; step();
        check("bp_second", 32'(disp_tag), 32'd15);
        step();

        // Fill to DEPTH, ignored extra issue, then flush
        for (int i = 0; i < DEPTH; i++) begin
            iss(6'(i), 5'(i + 1), 5'd31, 32'h0, 5'd0, 32'h0);
            if (i == DEPTH - 1) begin
                #1 check("full_next_full", 32'(next_full), 32'd1);
            end
            step();
        end
        iss(6'd63, 5'd30, 5'd0, 32'h0, 5'd0, 32'h0); step();
        check("full_ignored", 32'(count), 32'(DEPTH));
        clr = 1'b1; step();
        check("clr_count", 32'(count), 32'd0);
        check("clr_disp_valid", 32'(disp_valid), 32'd0);

        // Asynchronous reset in the middle of operation
        disp_ready = 1'b0;
        iss(6'd11, 5'd16, 5'd0, 32'h7, 5'd0, 32'h8); step();
        for (int i = 0; i < 4; i++) begin
            iss(6'd12, 5'(17 + i), 5'd30, 32'h0, 5'd0, 32'h0); step();
        end
        #3 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_disp_valid", 32'(disp_valid), 32'd0);
        check("arst_next_full", 32'(next_full), 32'd0);
        m_clear();
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rdy        = ($urandom_range(0, 9) != 0);
            clr        = ($urandom_range(0, 49) == 0);
            disp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 6 && (mq.size() < DEPTH || $urandom_range(0, 19) == 0)) begin
                iss(6'($urandom_range(0, 63)), 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom,
                    ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom);
            end
            for (int k = 0; k < N_CDB; k++) begin
                if ($urandom_range(0, 9) < 4) cdb(k, 5'($urandom_range(1, 7)), $urandom);
            end
            step();
        end
        clr = 1'b1; step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
